lc3x_md_sequencer: RTL and testbench
====================================

// Module: lc3x_md_sequencer
// PURPOSE
//  Sequences the shared multi-cycle multiplier and divider IP cores in the EX stage for
//  LC-3X MUL/DIV instructions. Gates each core's clock enable for exactly its latency.
//  Holds ex_stall until the result is captured, then presents a registered result to the
//  lc3x result mux. Also handles flush, abort and divide-by-zero.
// PARAMETERS
//  MUL_LAT      3        enabled clock edges from operands-in to valid multiplier output (>=1)
//  DIV_LAT      7        enabled clock edges from operands-in to valid divider quotient (>=1)
//  CNT_W        4        latency counter width; must hold max(MUL_LAT,DIV_LAT)-1
//  DIVZ_RESULT  16'hFFFF quotient returned for divide by zero
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  md_req        in   1   EX holds a valid mult_div instruction (control word mult_div & stage valid)
//  md_op         in   3   ex_ir[5:3]: 3'b000 = MUL, 3'b001 = DIV, others unsupported
//  divisor_zero  in   1   divider denom operand == 16'h0000 (valid with md_req)
//  mul_result    in   16  multiplier_out[15:0]
//  div_result    in   16  divider quotient
//  pipe_advance  in   1   EX->MEM latch loads this cycle (no downstream stall)
//  flush         in   1   kill the instruction in EX (branch/trap redirect)
//  mul_en        out  1   multiplier clock enable
//  div_en        out  1   divider clock enable
//  ex_stall      out  1   hold IF/ID/EX; freeze EX operands
//  md_result     out  16  registered MUL/DIV result
//  md_valid      out  1   md_result valid for the instruction in EX
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, md_result=16'h0000. All outputs 0.
//  States: IDLE, MUL_RUN, DIV_RUN, DONE. Only one core is enabled in any cycle.
//  IDLE:
//   - md_req & MUL: mul_en=1, ex_stall=1, cnt<=MUL_LAT-1, go to MUL_RUN.
//   - md_req & DIV & !divisor_zero: div_en=1, ex_stall=1, cnt<=DIV_LAT-1, go to DIV_RUN.
//   - md_req & DIV & divisor_zero: div_en=0, ex_stall=1, md_result<=DIVZ_RESULT, go to DONE.
//   - md_req with other md_op: ignored. No stall, no enable, stay IDLE.
//  x_RUN (x=MUL/DIV):
//   - ex_stall=1.
//   - cnt!=0: x_en=1, cnt<=cnt-1.
//   - cnt==0: x_en=0, md_result<=x_result, go to DONE.
//  DONE:
//   - ex_stall=0, md_valid=1, md_result held.
//   - pipe_advance: go to IDLE. Otherwise stay in DONE; no re-issue while MEM is stalled.
//  Timing:
//   - Each core sees exactly LAT enabled edges per op: the IDLE edge plus LAT-1 RUN edges.
//   - ex_stall is high for 1+LAT cycles: MUL 4 cycles, DIV 8 cycles (defaults).
//   - Divide by zero stalls 1 cycle.
//  Back-to-back ops: the DONE->IDLE cycle is followed by IDLE seeing the next md_req.
//   The next op starts the cycle after advance, with no extra bubble.
//  flush (any state, priority over everything): go to IDLE, cnt<=0.
//   Same cycle: ex_stall=0, mul_en=0, div_en=0. md_result unchanged, md_valid=0 next cycle.
//  md_req falling in x_RUN without flush: treated as abort, same action as flush.
//  md_op or operands changing mid-RUN: ignored. EX is frozen by ex_stall; the latched op
//   is defined by the state.
//  Reset mid-operation: immediate return to IDLE, enables drop asynchronously.
//  ex_stall, mul_en and div_en are combinational from state, cnt, md_req, md_op, divisor_zero
//   and flush. md_valid and busy are decoded from state only.
// TESTING
//  MUL 7*6, pipe_advance=1 -> mul_en high 3 cycles, ex_stall high 4 cycles.
//   Then md_valid=1, md_result=16'h002A; div_en never asserted.
//  DIV 100/7 -> div_en high 7 cycles, ex_stall high 8 cycles, md_result=16'h000E.
//  DIV 5/0 -> ex_stall high 1 cycle, div_en never high, md_result=16'hFFFF next cycle.
//  MUL completes with pipe_advance=0 for 3 cycles -> DONE held.
//   ex_stall=0, md_result stable, mul_en=0 throughout; IDLE after advance.
//  flush in 3rd DIV_RUN cycle -> next cycle IDLE.
//   div_en=0 and ex_stall=0 in the flush cycle; a new MUL then completes correctly.
//  rst_n low during MUL_RUN -> all outputs 0 immediately.
//   md_req with md_op=3'b010 -> no stall, no enable, busy=0.

Source files
------------

// File: rtl/lc3x_md_sequencer.sv
// EX-stage sequencer for the shared multi-cycle multiplier/divider cores.
// Gates each core's clock enable for its latency, stalls EX, and registers the result.
module lc3x_md_sequencer #(
  parameter int          MUL_LAT     = 3,
  parameter int          DIV_LAT     = 7,
  parameter int          CNT_W       = 4,
  parameter logic [15:0] DIVZ_RESULT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_req,
  input  logic [2:0]  md_op,
  input  logic        divisor_zero,
  input  logic [15:0] mul_result,
  input  logic [15:0] div_result,
  input  logic        pipe_advance,
  input  logic        flush,
  output logic        mul_en,
  output logic        div_en,
  output logic        ex_stall,
  output logic [15:0] md_result,
  output logic        md_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       md_result_q, md_result_d;
  logic              is_mul, is_div;

  assign is_mul = (md_op == 3'b000);
  assign is_div = (md_op == 3'b001);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_result_d = md_result_q;
    mul_en      = 1'b0;
    div_en      = 1'b0;
    ex_stall    = 1'b0;
    // Reset gates the combinational outputs so enables drop the moment rst_n falls.
    if (flush || !rst_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md_req && is_mul) begin
            mul_en   = 1'b1;
            ex_stall = 1'b1;
            cnt_d    = MUL_CNT0;
            state_d  = MUL_RUN;
          end else if (md_req && is_div && !divisor_zero) begin
            div_en   = 1'b1;
            ex_stall = 1'b1;
            cnt_d    = DIV_CNT0;
            state_d  = DIV_RUN;
          end else if (md_req && is_div) begin
            ex_stall    = 1'b1;
            md_result_d = DIVZ_RESULT;
            state_d     = DONE;
          end
        end
        MUL_RUN, DIV_RUN: begin
          // A dropped request mid-run is an abort, handled like a flush.
          if (!md_req) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            ex_stall = 1'b1;
            if (cnt_q != '0) begin
              mul_en = (state_q == MUL_RUN);
              div_en = (state_q == DIV_RUN);
              cnt_d  = cnt_q - CNT_W'(1);
            end else begin
              md_result_d = (state_q == MUL_RUN) ? mul_result : div_result;
              state_d     = DONE;
            end
          end
        end
        DONE: begin
          if (pipe_advance) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      md_result_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_result_q <= md_result_d;
    end
  end

  assign md_result = md_result_q;
  assign md_valid  = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lc3x_md_sequencer.sv
// Directed self-checking bench for lc3x_md_sequencer (default latencies MUL 3, DIV 7).
module tb_lc3x_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_req, divisor_zero, pipe_advance, flush;
  logic [2:0]  md_op;
  logic [15:0] mul_result, div_result;
  logic        mul_en, div_en, ex_stall, md_valid, busy;
  logic [15:0] md_result;

  int n_chk = 0;
  int n_err = 0;

  lc3x_md_sequencer dut (
    .clk(clk), .rst_n(rst_n), .md_req(md_req), .md_op(md_op),
    .divisor_zero(divisor_zero), .mul_result(mul_result), .div_result(div_result),
    .pipe_advance(pipe_advance), .flush(flush), .mul_en(mul_en), .div_en(div_en),
    .ex_stall(ex_stall), .md_result(md_result), .md_valid(md_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue an op right after a rising edge and count enabled/stalled cycles until md_valid.
  task automatic run_op(input logic [2:0] op, input logic dz,
                        output int n_stall, output int n_mul, output int n_div);
    bit ok;
    n_stall = 0; n_mul = 0; n_div = 0; ok = 0;
    @(posedge clk); #1;
    md_req = 1'b1; md_op = op; divisor_zero = dz;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (md_valid) begin ok = 1; break; end
      n_stall += int'(ex_stall);
      n_mul   += int'(mul_en);
      n_div   += int'(div_en);
    end
    chk("op_timeout", 32'(ok), 32'd1);
  endtask

  int s, m, d;
  logic [15:0] held;

  initial begin
    rst_n = 1'b0; md_req = 0; md_op = 0; divisor_zero = 0; pipe_advance = 1;
    flush = 0; mul_result = 0; div_result = 0;
    #12;
    chk("rst_mul_en", 32'(mul_en), 0);
    chk("rst_div_en", 32'(div_en), 0);
    chk("rst_stall",  32'(ex_stall), 0);
    chk("rst_valid",  32'(md_valid), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_result", 32'(md_result), 0);
    @(negedge clk); rst_n = 1'b1;

    // MUL 7*6
    mul_result = 16'd42; div_result = 16'h1234;
    run_op(3'b000, 1'b0, s, m, d);
    chk("mul_en_cycles", 32'(m), 3);
    chk("mul_stall_cycles", 32'(s), 4);
    chk("mul_div_en", 32'(d), 0);
    chk("mul_result", 32'(md_result), 32'h002A);
    chk("mul_done_stall", 32'(ex_stall), 0);
    md_req = 1'b0;
    @(negedge clk);
    chk("mul_back_idle", 32'(busy), 0);

    // DIV 100/7
    div_result = 16'd14;
    run_op(3'b001, 1'b0, s, m, d);
    chk("div_en_cycles", 32'(d), 7);
    chk("div_stall_cycles", 32'(s), 8);
    chk("div_mul_en", 32'(m), 0);
    chk("div_result", 32'(md_result), 32'h000E);
    md_req = 1'b0;
    @(negedge clk);

    // DIV 5/0
    div_result = 16'h1234;
    run_op(3'b001, 1'b1, s, m, d);
    chk("divz_stall_cycles", 32'(s), 1);
    chk("divz_div_en", 32'(d), 0);
    chk("divz_result", 32'(md_result), 32'hFFFF);
    md_req = 1'b0; divisor_zero = 1'b0;
    @(negedge clk);

    // MUL held in DONE while MEM stalls
    mul_result = 16'd21; pipe_advance = 1'b0;
    run_op(3'b000, 1'b0, s, m, d);
    held = md_result;
    chk("hold_result0", 32'(held), 32'h0015);
    mul_result = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(md_valid), 1);
      chk("hold_stall", 32'(ex_stall), 0);
      chk("hold_mul_en", 32'(mul_en), 0);
      chk("hold_result", 32'(md_result), 32'h0015);
    end
    pipe_advance = 1'b1; md_req = 1'b0;
    @(negedge clk);
    chk("hold_released", 32'(busy), 0);
    chk("hold_valid_off", 32'(md_valid), 0);

    // Flush in the third DIV_RUN cycle, then a fresh MUL
    @(posedge clk); #1;
    md_req = 1'b1; md_op = 3'b001;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_div_en", 32'(div_en), 0);
    chk("flush_stall", 32'(ex_stall), 0);
    @(posedge clk); #1;
    flush = 1'b0; md_req = 1'b0;
    @(negedge clk);
    chk("flush_idle", 32'(busy), 0);
    chk("flush_valid", 32'(md_valid), 0);
    chk("flush_result_kept", 32'(md_result), 32'h0015);
    mul_result = 16'd99;
    run_op(3'b000, 1'b0, s, m, d);
    chk("post_flush_mul_en", 32'(m), 3);
    chk("post_flush_result", 32'(md_result), 32'h0063);

    // Back-to-back: DIV issued on the DONE->IDLE edge, no bubble
    div_result = 16'd9;
    run_op(3'b001, 1'b0, s, m, d);
    chk("b2b_div_en", 32'(d), 7);
    chk("b2b_stall", 32'(s), 8);
    chk("b2b_result", 32'(md_result), 32'h0009);
    md_req = 1'b0;
    @(negedge clk);

    // Abort: md_req drops during MUL_RUN
    @(posedge clk); #1;
    md_req = 1'b1; md_op = 3'b000;
    @(posedge clk); #1;
    md_req = 1'b0;
    @(negedge clk);
    chk("abort_mul_en", 32'(mul_en), 0);
    chk("abort_stall", 32'(ex_stall), 0);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);

    // Reset during MUL_RUN
    @(posedge clk); #1;
    md_req = 1'b1; md_op = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_mul_en", 32'(mul_en), 0);
    chk("arst_stall", 32'(ex_stall), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_result", 32'(md_result), 0);
    md_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Unsupported op is ignored
    @(posedge clk); #1;
    md_req = 1'b1; md_op = 3'b010;
    @(negedge clk);
    chk("unsup_stall", 32'(ex_stall), 0);
    chk("unsup_en", 32'({mul_en, div_en}), 0);
    @(negedge clk);
    chk("unsup_busy", 32'(busy), 0);
    md_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
